// File: rtl/serial_pkg.sv
// serial_pkg: receiver state encoding and line-level constants shared with the transmitter side
package serial_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/rx_shreg.sv
// rx_shreg: right-shift register, new bit enters at the MSB so an LSB-first stream lands in order
module rx_shreg #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         shift,
   input  logic         din,
   output logic [W-1:0] q
);
   // shift in from the top on each enabled edge, clear has priority
   always_ff @(posedge clk)
      if (clr) q <= '0;
      else if (shift) q <= {din, q[W-1:1]};
endmodule

// File: rtl/serial_rx.sv
// serial_rx: LSB-first framed serial receiver with optional even parity and stop-bit checking
module serial_rx import serial_pkg::*; #(
   parameter int DATA_W = 4,
   parameter int PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sin,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);
   localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic [DATA_W-1:0] sr;
   logic err_p;
   rx_shreg #(.W(DATA_W)) u_shreg (
      .clk(clk),
      .clr(rst),
      .shift(en && state == DATA),
      .din(sin),
      .q(sr)
   );
   assign busy = state != IDLE;
   // frame sequencing; pulses default low each cycle so they last exactly one cycle regardless of en
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         dout <= '0;
         err_p <= 1'b0;
         valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err <= 1'b0;
         if (en)
            case (state)
               IDLE: if (sin == START_BIT) begin
                  state <= DATA;
                  cnt <= '0;
                  err_p <= 1'b0;
               end
               DATA: begin
                  cnt <= cnt == LAST ? '0 : cnt + 1'b1;
                  if (cnt == LAST) state <= PARITY_EN != 0 ? PARITY : STOP;
               end
               PARITY: begin
                  err_p <= ^{sr, sin};
                  state <= STOP;
               end
               STOP: begin
                  if (sin == STOP_BIT) begin
                     dout <= sr;
                     valid <= 1'b1;
                     parity_err <= PARITY_EN != 0 && err_p;
                  end else frame_err <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: table-driven frame checks plus hand sequences for en gaps, mid-frame reset and back-to-back frames
module tb_serial_rx;
   logic clk = 1'b0;
   logic rst, en, sin;
   logic [3:0] dout;
   logic valid, parity_err, frame_err, busy;
   int total = 0;
   int bad = 0;
   typedef struct {
      logic [6:0] seq;
      logic [3:0] dout;
      logic       valid;
      logic       perr;
      logic       ferr;
   } vec_t;
   vec_t vecs[6];
   logic [6:0] s;
   int first_v;
   int pulses[$];
   serial_rx #(.DATA_W(4), .PARITY_EN(1)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .sin(sin),
      .dout(dout),
      .valid(valid),
      .parity_err(parity_err),
      .frame_err(frame_err),
      .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step(input logic e, input logic b);
      en = e;
      sin = b;
      @(posedge clk);
      #1;
   endtask
   initial begin
      // seq[i] is the line level on the i-th sampled edge: start, d0..d3, parity, stop
      vecs[0] = '{7'b1001010, 4'b0101, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{7'b1110000, 4'b1000, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{7'b1010000, 4'b1000, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{7'b0001010, 4'b1000, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{7'b1011110, 4'b1111, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{7'b1100110, 4'b0011, 1'b1, 1'b1, 1'b0};
      rst = 1'b1;
      en = 1'b0;
      sin = 1'b1;
      @(posedge clk);
      step(1'b1, 1'b0);
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_perr", 32'(parity_err), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      step(1'b1, 1'b1);
      chk("idle_busy", 32'(busy), 32'h0);
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 7; i++) begin
            step(1'b1, vecs[v].seq[i]);
            if (i == 0) chk($sformatf("v%0d_busy_start", v), 32'(busy), 32'h1);
            if (i < 6) chk($sformatf("v%0d_nopulse%0d", v, i), 32'({valid, frame_err}), 32'h0);
         end
         chk($sformatf("v%0d_dout", v), 32'(dout), 32'(vecs[v].dout));
         chk($sformatf("v%0d_valid", v), 32'(valid), 32'(vecs[v].valid));
         chk($sformatf("v%0d_perr", v), 32'(parity_err), 32'(vecs[v].perr));
         chk($sformatf("v%0d_ferr", v), 32'(frame_err), 32'(vecs[v].ferr));
         chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'h0);
         step(1'b1, 1'b1);
         chk($sformatf("v%0d_pulse_clear", v), 32'({valid, parity_err, frame_err}), 32'h0);
      end
      // en toggling 1,0: disabled edges drive the opposite level to prove they are ignored
      s = vecs[0].seq;
      first_v = -1;
      for (int k = 0; k < 14; k++) begin
         step(k % 2 == 0, (k % 2 == 0) ? s[k / 2] : ~s[k / 2]);
         if (valid && first_v < 0) begin
            first_v = k + 1;
            chk("gap_dout", 32'(dout), 32'h5);
            chk("gap_perr", 32'(parity_err), 32'h0);
         end
         if (k == 13) chk("gap_valid_drop_en0", 32'(valid), 32'h0);
      end
      chk("gap_latency_cycles", 32'(first_v), 32'd13);
      chk("gap_busy_end", 32'(busy), 32'h0);
      // reset after the second data bit aborts the frame silently
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      rst = 1'b1;
      step(1'b1, 1'b0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_pulses", 32'({valid, frame_err}), 32'h0);
      chk("abort_dout", 32'(dout), 32'h0);
      rst = 1'b0;
      step(1'b1, 1'b1);
      chk("abort_after_pulses", 32'({valid, frame_err, busy}), 32'h0);
      s = vecs[1].seq;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, s[i]);
         if (i < 6) chk($sformatf("abort_fresh_nopulse%0d", i), 32'({valid, frame_err}), 32'h0);
      end
      chk("abort_fresh_dout", 32'(dout), 32'h8);
      chk("abort_fresh_valid", 32'(valid), 32'h1);
      // two frames with no idle bit between them
      step(1'b1, 1'b1);
      for (int k = 0; k < 14; k++) begin
         step(1'b1, k < 7 ? vecs[0].seq[k] : vecs[1].seq[k - 7]);
         if (valid) begin
            pulses.push_back(k);
            chk($sformatf("b2b_dout%0d", pulses.size()), 32'(dout), pulses.size() == 1 ? 32'h5 : 32'h8);
         end
      end
      chk("b2b_count", 32'(pulses.size()), 32'd2);
      if (pulses.size() == 2) chk("b2b_spacing", 32'(pulses[1] - pulses[0]), 32'd7);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
